// File: rtl/inv_key_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_scheduler
// Purpose  : Iterative inverse AES-128 key schedule. Captures the final round
//            key and steps the schedule backwards, presenting round keys
//            NUM_ROUNDS, NUM_ROUNDS-1, ... 0 one per accepted valid/ready
//            transfer. The decryption round engine therefore needs no
//            11-entry key store.
// Ports    : clk        - system clock, rising edge
//            n_rst      - asynchronous active-low reset
//            start      - pulse: capture final_key, begin a backward sweep
//            final_key  - round-NUM_ROUNDS key, word0 = [127:96]
//            key_ready  - consumer accepts key_out this cycle
//            key_out    - current round key (registered)
//            round_idx  - round number of key_out
//            key_valid  - key_out/round_idx hold a valid key
//            busy       - sweep in progress
//            done       - one-cycle pulse after the round-0 key is accepted
// Params   : NUM_ROUNDS - index of the first key emitted, legal 1..10
// Revision : 1.0 - initial release
// ============================================================================
module inv_key_scheduler #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] final_key,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t         state_q;
  logic [127:0]   key_q;
  logic [3:0]     round_q;
  logic           valid_q;
  logic           busy_q;
  logic           done_q;
  logic [127:0]   prev_key_d;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return C_SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Rcon used when round key r was generated going forwards.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Undo one forward expansion step. Words 1..3 unwind by XOR alone; p3 is
  // then the previous key's last word, which is what g() consumed going
  // forwards, so word 0 can be recovered with a single 4-byte S-box pass.
  always_comb begin
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot_w, sub_w;
    w0         = key_q[127:96];
    w1         = key_q[95:64];
    w2         = key_q[63:32];
    w3         = key_q[31:0];
    p3         = w3 ^ w2;
    p2         = w2 ^ w1;
    p1         = w1 ^ w0;
    rot_w      = {p3[23:0], p3[31:24]};
    sub_w      = {sub_byte(rot_w[31:24]), sub_byte(rot_w[23:16]),
                  sub_byte(rot_w[15:8]),  sub_byte(rot_w[7:0])};
    p0         = w0 ^ sub_w ^ {rcon(round_q), 24'h0};
    prev_key_d = {p0, p1, p2, p3};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start that lands on the done pulse belongs to the old sweep.
          if (start && !done_q) begin
            state_q <= S_EMIT;
            key_q   <= final_key;
            round_q <= 4'(NUM_ROUNDS);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_EMIT: begin
          if (valid_q && key_ready) begin
            if (round_q != 4'd0) begin
              key_q   <= prev_key_d;
              round_q <= round_q - 4'd1;
            end else begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_out   = key_q;
  assign round_idx = round_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_key_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_key_scheduler
// Purpose  : Self-checking bench for inv_key_scheduler. A forward AES-128 key
//            expansion (S-box derived from GF(2^8) inversion plus the affine
//            map) supplies the expected round keys, which the DUT must emit in
//            reverse order. A second instance covers NUM_ROUNDS = 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_key_scheduler;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [127:0] final_key;
  logic         key_ready;
  logic [127:0] key_out;
  logic [3:0]   round_idx;
  logic         key_valid, busy, done;

  logic         s1_start;
  logic [127:0] s1_final_key;
  logic         s1_key_ready;
  logic [127:0] s1_key_out;
  logic [3:0]   s1_round_idx;
  logic         s1_key_valid, s1_busy, s1_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_k  [11];

  always #5 clk = ~clk;

  inv_key_scheduler #(.NUM_ROUNDS(10)) u_dut (
    .clk(clk), .n_rst(n_rst), .start(start), .final_key(final_key),
    .key_ready(key_ready), .key_out(key_out), .round_idx(round_idx),
    .key_valid(key_valid), .busy(busy), .done(done)
  );

  inv_key_scheduler #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(s1_start), .final_key(s1_final_key),
    .key_ready(s1_key_ready), .key_out(s1_key_out), .round_idx(s1_round_idx),
    .key_valid(s1_key_valid), .busy(s1_busy), .done(s1_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (b != 0 && gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon_m(input int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < n; i++) rc = xtime(rc);
    return rc;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_m(i/4), 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One backward sweep on the NUM_ROUNDS=10 instance. Use -1 to disable a
  // stall, a start injection while busy, or a reset abort.
  task automatic do_sweep(input logic [127:0] fk, input int stall_round, input int stall_len,
                          input int inject_round, input int abort_round, input bit start_on_done);
    @(negedge clk);
    start = 1'b1; final_key = fk; key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      if (r == abort_round) begin
        #2 n_rst = 1'b0;
        #1;
        chk("abort key_out",   key_out,   128'h0);
        chk("abort round_idx", 128'(round_idx), 128'h0);
        chk("abort key_valid", 128'(key_valid), 128'h0);
        chk("abort busy",      128'(busy),      128'h0);
        chk("abort done",      128'(done),      128'h0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post-abort idle", 128'(key_valid), 128'h0);
        return;
      end
      if (r == stall_round) begin
        key_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk($sformatf("stall key r%0d", r),   key_out,          exp_k[r]);
          chk($sformatf("stall idx r%0d", r),   128'(round_idx),  128'(r));
          chk($sformatf("stall valid r%0d", r), 128'(key_valid),  128'h1);
          @(negedge clk);
        end
        key_ready = 1'b1;
      end
      chk($sformatf("key r%0d", r),   key_out,         exp_k[r]);
      chk($sformatf("idx r%0d", r),   128'(round_idx), 128'(r));
      chk($sformatf("valid r%0d", r), 128'(key_valid), 128'h1);
      chk($sformatf("nodone r%0d", r), 128'(done),     128'h0);
      if (r == inject_round) begin
        start = 1'b1; final_key = ~fk;
      end
      @(negedge clk);
      start = 1'b0; final_key = fk;
    end
    chk("done pulse",  128'(done),      128'h1);
    chk("done valid",  128'(key_valid), 128'h0);
    chk("done busy",   128'(busy),      128'h0);
    if (start_on_done) begin
      start = 1'b1; final_key = ~fk;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done cleared", 128'(done), 128'h0);
    if (start_on_done) begin
      chk("start@done valid", 128'(key_valid), 128'h0);
      chk("start@done busy",  128'(busy),      128'h0);
    end
  endtask

  initial begin
    logic [127:0] rk;
    n_rst = 1'b0; start = 1'b0; final_key = '0; key_ready = 1'b0;
    s1_start = 1'b0; s1_final_key = '0; s1_key_ready = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    chk("rst key_out",   key_out,         128'h0);
    chk("rst round_idx", 128'(round_idx), 128'h0);
    chk("rst key_valid", 128'(key_valid), 128'h0);
    chk("rst busy",      128'(busy),      128'h0);
    chk("rst done",      128'(done),      128'h0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle no start", 128'(key_valid), 128'h0);

    // FIPS-197 vector, straight through
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    do_sweep(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, 0, -1, -1, 1'b0);
    chk("fips round0 literal", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // backpressure at round 7, start while busy, start on done
    do_sweep(exp_k[10], 7, 5, -1, -1, 1'b0);
    do_sweep(exp_k[10], -1, 0, 6, -1, 1'b1);

    // async reset at round 4, then a fresh full sweep
    do_sweep(exp_k[10], -1, 0, -1, 4, 1'b0);
    do_sweep(exp_k[10], -1, 0, -1, -1, 1'b0);

    // random keys through the forward model
    for (int k = 0; k < 3; k++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      expand(rk);
      do_sweep(exp_k[10], (k == 1) ? int'($urandom_range(0, 10)) : -1, 3, -1, -1, 1'b0);
    end

    // NUM_ROUNDS = 1 instance
    @(negedge clk);
    s1_start = 1'b1; s1_final_key = 128'ha0fafe1788542cb123a339392a6c7605; s1_key_ready = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    chk("n1 key r1",   s1_key_out,         128'ha0fafe1788542cb123a339392a6c7605);
    chk("n1 idx r1",   128'(s1_round_idx), 128'h1);
    chk("n1 valid r1", 128'(s1_key_valid), 128'h1);
    @(negedge clk);
    chk("n1 key r0",   s1_key_out,         128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("n1 idx r0",   128'(s1_round_idx), 128'h0);
    @(negedge clk);
    chk("n1 done",     128'(s1_done),      128'h1);
    chk("n1 valid off", 128'(s1_key_valid), 128'h0);
    @(negedge clk);
    chk("n1 done cleared", 128'(s1_done), 128'h0);

    if (n_fail != 0) $display("note: %0d check(s) did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
